divider: RTL and testbench

- Sequential unsigned restoring divider; the inverse of the shift-add multiplier in the same datapath.
- Accepts a WIDTH-bit dividend and divisor on a start strobe.
- Produces one quotient bit per clock (shift-subtract), then presents quotient and remainder with a one-cycle done pulse.
- Used wherever the arithmetic block needs a division without a combinational divider.

---
 rtl/divider.sv | 126 ++++++++++++
 tb/tb_divider.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, then a
// one-cycle done pulse with quotient, remainder and divide-by-zero flag held.
module divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned REM_W = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [REM_W-1:0]   rem_w_q, rem_w_d;
  logic [WIDTH-1:0]   quo_w_q, quo_w_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [REM_W-1:0]   rem_shift;
  logic [REM_W-1:0]   trial;
  logic               fits;
  logic [REM_W-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  // One shift-subtract iteration plus the IDLE/RUN/DONE sequencing
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_w_d     = rem_w_q;
    quo_w_d     = quo_w_q;
    dsr_d       = dsr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    // The extra remainder bit keeps the trial subtraction from overflowing
    rem_shift = REM_W'({rem_w_q, quo_w_q[WIDTH-1]});
    trial     = rem_shift - {1'b0, dsr_q};
    fits      = (rem_shift >= {1'b0, dsr_q});
    rem_step  = fits ? trial : rem_shift;
    quo_step  = {quo_w_q[WIDTH-2:0], fits};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
            dsr_d   = divisor;
            rem_w_d = '0;
            quo_w_d = dividend;
            count_d = '0;
          end
        end
      end
      RUN: begin
        rem_w_d = rem_step;
        quo_w_d = quo_step;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_ITER) begin
          state_d     = DONE;
          quotient_d  = quo_step;
          remainder_d = rem_step[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_w_q     <= '0;
      quo_w_q     <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_w_q     <= rem_w_d;
      quo_w_q     <= quo_w_d;
      dsr_q       <= dsr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: expected results are queued at issue time and
// popped by an independent monitor whenever done is seen.
module tb_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done cycle must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.z));
        check("busy_with_done", 32'(busy), 32'd1);
        if (!e.z) begin
          check("inv_recombine", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
          check("inv_rem_lt_div", 32'(remainder < e.b), 32'd1);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one operation; returns at the negedge after the accepting edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int sel;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_q", 32'(quotient), 32'd0);
    check("reset_r", 32'(remainder), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic op with latency profile: busy for 9 cycles, done on the last
    issue(8'd200, 8'd7);
    for (int j = 0; j <= 9; j++) begin
      check("lat_busy", 32'(busy), 32'(j <= 8));
      check("lat_done", 32'(done), 32'(j == 8));
      if (j < 9) @(negedge clk);
    end

    // Limits
    issue(8'd255, 8'd1);
    issue(8'd255, 8'd255);
    issue(8'd5, 8'd9);
    issue(8'd0, 8'd3);

    // Divide by zero finishes in the cycle right after acceptance
    issue(8'd13, 8'd0);
    check("dbz_done_now", 32'(done), 32'd1);
    issue(8'd10, 8'd3);

    // start held high through RUN and DONE with different operands
    wait_idle();
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    sb.push_back(model(8'd200, 8'd7));
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hold_done_seen", 32'(done), 32'd1);
    sb.push_back(model(8'd50, 8'd5));
    @(negedge clk);
    check("hold_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    check("hold_reaccept", 32'(busy), 32'd1);
    start = 1'b0;

    // Reset in the middle of an operation; no result may follow
    wait_idle();
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_q", 32'(quotient), 32'd0);
    check("midrst_r", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_pending", 32'(sb.size()), 32'd0);

    // Randomized back-to-back operations, biased toward edge divisors
    for (int i = 0; i < 1500; i++) begin
      a   = W'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 15));
      if (sel == 0)      b = '0;
      else if (sel == 1) b = W'(1);
      else if (sel == 2) b = '1;
      else               b = W'($urandom_range(0, 255));
      if (sel == 3) a = '1;
      issue(a, b);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("final_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
